mega_logic_unit: RTL and testbench
==================================

# mega_logic_unit

Parametrised, pipelined bitwise logic unit and the successor to the fixed 64-bit AND. It performs one of eight bitwise operations on two WIDTH-bit operands, or folds a multi-beat packet of operands into a single result (accumulate mode). It sits on a valid/ready stream between a datapath producer and consumer. It registers its result, all-zero/all-one flags and a beat count.

## Interface

Parameters:
- WIDTH, 64, operand/result width (≥1)
- CNT_W, 8, width of the beat counter on the output

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  unit can accept a beat this cycle
- op  in  3  operation select, sampled per beat (accumulate: sampled on first beat only)
- accum  in  1  beat belongs to an accumulate packet
- last  in  1  final beat of accumulate packet (ignored when accum=0)
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (ignored when accum=1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- R  out  WIDTH  result
- zero  out  1  R == 0
- ones  out  1  R == all ones
- count  out  CNT_W  beats folded into R (1 for element-wise), saturating at 2^CNT_W−1

## Operation

- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (A & ~B), 7 PASS (A).
- Beat accepted when in_valid && in_ready.
- Element-wise (accum=0): R ← A op B, count ← 1, out_valid ← 1. Packet state is unaffected, so an element-wise beat may be interleaved mid-packet.
- Accumulate (accum=1), internal state acc[WIDTH], acc_op[3], cnt[CNT_W], first (reset 1):
  - First beat (first=1): acc ← A, acc_op ← op, cnt ← 1, first ← 0.
  - Later beats: acc ← acc acc_op A. For NAND/NOR/XNOR this means the negated op applied pairwise left-to-right. PASS keeps the newest A. ANDN gives acc & ~A. cnt increments and saturates.
  - Last beat: the folded value, including this beat, goes to R, count, zero and ones. out_valid ← 1 and first ← 1.
  - A single-beat packet (first && last) gives R = A, count = 1.
  - Non-last accumulate beats produce no output.
- zero and ones are computed from the value being registered into R, not from the old R. For WIDTH=1 both can be evaluated independently.
- Reset: out_valid 0, R 0, zero 0, ones 0, count 0, acc 0, cnt 0, first 1, acc_op 0. A packet in flight is discarded.

## Timing

- Latency is 1 cycle: a beat accepted at edge n gives the result visible after edge n (out_valid high in cycle n+1).
- in_ready = !out_valid || out_ready. This is combinational from out_ready, and there is no combinational path from in_valid to in_ready.
- Full throughput is one beat per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, R, zero, ones and count hold stable and in_ready=0. This applies to all beats, including non-last accumulate beats.
- Simultaneous accept of input and output in the same cycle: the output register reloads and out_valid stays 1.
- Once asserted, out_valid stays high until the result is accepted.
- rst overrides every other event in the same cycle.

## Structure

- Shared package mlu_pkg holds:
  - op enum mlu_op_e (AND..PASS, 3 bits)
  - function mlu_apply(op, a, b) returning a WIDTH-agnostic result (or a parametrised class/let)
- One sub-module: mlu_out_reg, the single-entry valid/ready output register carrying {R, zero, ones, count}. The fold/state logic stays in the top level.

## Test plan

- Element-wise sweep (WIDTH=64): A=0xF0F0_F0F0_F0F0_F0F0, B=0xFF00_FF00_FF00_FF00, op 0..7 back-to-back with out_ready=1:
  - required R: F000…, FFF0…, 0FF0…, 0FFF…, 000F…, F00F…, 00F0…, F0F0…
  - one result per cycle, 1-cycle latency, count=1
- Accumulate AND, 3 beats A=0xFF, 0x0F, 0x07 (WIDTH=8, last on beat 3) -> single output R=0x07, count=3, zero=0, ones=0. No output on beats 1–2.
- Accumulate XOR of 0xAA, 0xAA -> R=0x00, zero=1, count=2. A single-beat packet A=0xFF -> R=0xFF, ones=1, count=1.
- Backpressure: hold out_ready=0 for 4 cycles with a result pending -> in_ready=0 and R/count stable throughout. Release -> one transfer, then stream resumes with nothing lost or duplicated.
- Interleave: an element-wise beat inside an open OR packet (beats 0x01, then accum=0 AND 0x3C&0x0F, then 0x80 last) -> outputs R=0x0C (count 1), then R=0x81 (count 2).
- Reset mid-packet after 2 accumulate beats -> all outputs 0 next cycle. A following packet 0x55 last -> R=0x55, count=1, with no residue from the old acc. CNT_W=2 with a 5-beat packet -> count saturates at 3.

Source files
------------

// File: rtl/mlu_pkg.sv
// Shared types and the bitwise operation kernel for the mega logic unit.
package mlu_pkg;

    // Widest operand mlu_apply handles; callers zero-extend and truncate around it.
    localparam int unsigned MLU_MAX_W = 4096;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } mlu_op_e;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_OPEN = 1'b1
    } mlu_pkt_e;

    function automatic logic [MLU_MAX_W-1:0] mlu_apply(
        input mlu_op_e              op,
        input logic [MLU_MAX_W-1:0] a,
        input logic [MLU_MAX_W-1:0] b
    );
        case (op)
            OP_AND:  mlu_apply = a & b;
            OP_OR:   mlu_apply = a | b;
            OP_XOR:  mlu_apply = a ^ b;
            OP_NAND: mlu_apply = ~(a & b);
            OP_NOR:  mlu_apply = ~(a | b);
            OP_XNOR: mlu_apply = ~(a ^ b);
            OP_ANDN: mlu_apply = a & ~b;
            default: mlu_apply = a;
        endcase
    endfunction

endpackage

// File: rtl/mlu_out_reg.sv
// Single-entry valid/ready output register holding {R, zero, ones, count}.
module mlu_out_reg #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d_r,
    input  logic             d_zero,
    input  logic             d_ones,
    input  logic [CNT_W-1:0] d_count,
    input  logic             out_ready,
    output logic             ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] count
);

    assign ready = !out_valid || out_ready;

    // load is only raised by the parent when ready is high, so a reload
    // either fills an empty slot or replaces an entry leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            r         <= '0;
            zero      <= 1'b0;
            ones      <= 1'b0;
            count     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            r         <= d_r;
            zero      <= d_zero;
            ones      <= d_ones;
            count     <= d_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mega_logic_unit.sv
// Pipelined bitwise logic unit with element-wise and multi-beat accumulate modes.
module mega_logic_unit
    import mlu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             accum,
    input  logic             last,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] count
);

    mlu_pkt_e         state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    mlu_op_e          acc_op, acc_op_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic             first, accept, load;
    logic [WIDTH-1:0] elem_val, fold_val, res;
    logic [CNT_W-1:0] fold_cnt, res_cnt;

    assign first  = (state == PKT_IDLE);
    assign accept = in_valid && in_ready;
    assign load   = accept && (!accum || last);

    always_comb begin
        elem_val = WIDTH'(mlu_apply(mlu_op_e'(op), MLU_MAX_W'(A), MLU_MAX_W'(B)));
        fold_val = first ? A : WIDTH'(mlu_apply(acc_op, MLU_MAX_W'(acc), MLU_MAX_W'(A)));
        fold_cnt = first ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + CNT_W'(1));
        res      = accum ? fold_val : elem_val;
        res_cnt  = accum ? fold_cnt : CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PKT_IDLE;
            acc    <= '0;
            acc_op <= OP_AND;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            acc_op <= acc_op_nx;
            cnt    <= cnt_nx;
        end
    end

    // Element-wise beats leave packet state alone, so they may interleave mid-packet.
    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        acc_op_nx = acc_op;
        cnt_nx    = cnt;
        if (accept && accum) begin
            if (last) begin
                state_nx = PKT_IDLE;
            end else begin
                state_nx = PKT_OPEN;
                acc_nx   = fold_val;
                cnt_nx   = fold_cnt;
                if (first) acc_op_nx = mlu_op_e'(op);
            end
        end
    end

    mlu_out_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d_r       (res),
        .d_zero    (res == '0),
        .d_ones    (res == '1),
        .d_count   (res_cnt),
        .out_ready (out_ready),
        .ready     (in_ready),
        .out_valid (out_valid),
        .r         (R),
        .zero      (zero),
        .ones      (ones),
        .count     (count)
    );

endmodule

// File: tb/tb_mega_logic_unit.sv
// Scoreboard bench for mega_logic_unit: 64-bit, 8-bit and 8-bit/CNT_W=2 instances.
module tb_mega_logic_unit;

    logic        clk, rst;
    logic        in_valid, accum, last, out_ready;
    logic [2:0]  op;
    logic [63:0] a, b;

    logic        rdy64, ov64, z64, o64;
    logic [63:0] r64;
    logic [7:0]  c64;
    logic        rdy8, ov8, z8, o8;
    logic [7:0]  r8, c8;
    logic        rdys, ovs, zs, os;
    logic [7:0]  rs;
    logic [1:0]  cs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mega_logic_unit #(.WIDTH(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .op(op), .accum(accum),
        .last(last), .A(a), .B(b), .out_valid(ov64), .out_ready(out_ready), .R(r64),
        .zero(z64), .ones(o64), .count(c64));

    mega_logic_unit #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .op(op), .accum(accum),
        .last(last), .A(a[7:0]), .B(b[7:0]), .out_valid(ov8), .out_ready(out_ready), .R(r8),
        .zero(z8), .ones(o8), .count(c8));

    mega_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdys), .op(op), .accum(accum),
        .last(last), .A(a[7:0]), .B(b[7:0]), .out_valid(ovs), .out_ready(out_ready), .R(rs),
        .zero(zs), .ones(os), .count(cs));

    int          sel;
    logic        s_valid, s_ready, s_z, s_o;
    logic [63:0] s_r;
    logic [7:0]  s_c;

    always_comb begin
        s_valid = ov64; s_ready = rdy64; s_r = r64; s_z = z64; s_o = o64; s_c = c64;
        if (sel == 1) begin
            s_valid = ov8; s_ready = rdy8; s_r = {56'd0, r8}; s_z = z8; s_o = o8; s_c = c8;
        end else if (sel == 2) begin
            s_valid = ovs; s_ready = rdys; s_r = {56'd0, rs}; s_z = zs; s_o = os; s_c = {6'd0, cs};
        end
    end

    typedef struct {
        logic [63:0] r;
        logic        z;
        logic        o;
        logic [7:0]  c;
        int          cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   obs_rd;
    int   cyc;
    int   n_checks, n_pass;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every completed output transfer of the selected instance.
    always @(negedge clk) begin : monitor
        rec_t t;
        if (!rst && s_valid && out_ready) begin
            t.r = s_r; t.z = s_z; t.o = s_o; t.c = s_c; t.cyc = cyc;
            obs_q.push_back(t);
        end
    end

    function automatic rec_t mk(input logic [63:0] r, input logic z, input logic o,
                                input logic [7:0] c, input int cy);
        rec_t t;
        t.r = r; t.z = z; t.o = o; t.c = c; t.cyc = cy;
        return t;
    endfunction

    task automatic drive_beat(input logic [2:0] o_, input logic ac, input logic la,
                              input logic [63:0] a_, input logic [63:0] b_, output int acc_cyc);
        int waited;
        waited = 0;
        op = o_; accum = ac; last = la; a = a_; b = b_; in_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            n_checks++;
            $display("FAIL drive_beat: in_ready=%b after %0d cycles, required 1", s_ready, waited);
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((obs_q.size() - obs_rd) < exp_q.size() && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; accum = 1'b0; last = 1'b0; out_ready = 1'b1;
        op = 3'd0; a = '0; b = '0; sel = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ov8, r8, z8, o8, c8, rdy8} !== {1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1})
            $display("FAIL reset8: valid=%b R=%h zero=%b ones=%b count=%0d ready=%b, required 0 00 0 0 0 1",
                     ov8, r8, z8, o8, c8, rdy8);
        else n_pass++;
        n_checks++;
        if ({ov64, r64, z64, o64, c64, rdy64} !== {1'b0, 64'd0, 1'b0, 1'b0, 8'd0, 1'b1})
            $display("FAIL reset64: valid=%b R=%h zero=%b ones=%b count=%0d ready=%b, required 0 0 0 0 0 1",
                     ov64, r64, z64, o64, c64, rdy64);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_elementwise();
        logic [63:0] req [8] = '{64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0,
                                 64'h0FF0_0FF0_0FF0_0FF0, 64'h0FFF_0FFF_0FFF_0FFF,
                                 64'h000F_000F_000F_000F, 64'hF00F_F00F_F00F_F00F,
                                 64'h00F0_00F0_00F0_00F0, 64'hF0F0_F0F0_F0F0_F0F0};
        rec_t e, o;
        int   k;
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            drive_beat(3'(i), 1'b0, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, k);
            exp_q.push_back(mk(req[i], req[i] == 64'd0, req[i] == {64{1'b1}}, 8'd1, k + 1));
        end
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) $display("FAIL elementwise: no output, required R=%h", e.r);
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.r !== e.r || o.z !== e.z || o.o !== e.o || o.c !== e.c || (e.cyc >= 0 && o.cyc != e.cyc))
                    $display("FAIL elementwise: got R=%h z=%b o=%b cnt=%0d cyc=%0d, required R=%h z=%b o=%b cnt=%0d cyc=%0d",
                             o.r, o.z, o.o, o.c, o.cyc, e.r, e.z, e.o, e.c, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) $display("FAIL elementwise_extra: %0d extra outputs, required 0", obs_q.size() - obs_rd);
        else n_pass++;
        obs_rd = obs_q.size();
    endtask

    task automatic test_accumulate();
        rec_t e, o;
        int   k;
        sel = 1;
        drive_beat(3'd0, 1'b1, 1'b0, 64'hFF, 64'h00, k);
        drive_beat(3'd1, 1'b1, 1'b0, 64'h0F, 64'hFF, k);
        drive_beat(3'd1, 1'b1, 1'b1, 64'h07, 64'hFF, k);
        exp_q.push_back(mk(64'h07, 1'b0, 1'b0, 8'd3, k + 1));
        drive_beat(3'd2, 1'b1, 1'b0, 64'hAA, 64'h00, k);
        drive_beat(3'd2, 1'b1, 1'b1, 64'hAA, 64'h00, k);
        exp_q.push_back(mk(64'h00, 1'b1, 1'b0, 8'd2, k + 1));
        drive_beat(3'd3, 1'b1, 1'b1, 64'hFF, 64'hFF, k);
        exp_q.push_back(mk(64'hFF, 1'b0, 1'b1, 8'd1, k + 1));
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) $display("FAIL accumulate: no output, required R=%h", e.r);
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.r !== e.r || o.z !== e.z || o.o !== e.o || o.c !== e.c || (e.cyc >= 0 && o.cyc != e.cyc))
                    $display("FAIL accumulate: got R=%h z=%b o=%b cnt=%0d cyc=%0d, required R=%h z=%b o=%b cnt=%0d cyc=%0d",
                             o.r, o.z, o.o, o.c, o.cyc, e.r, e.z, e.o, e.c, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) $display("FAIL accumulate_extra: %0d extra outputs, required 0", obs_q.size() - obs_rd);
        else n_pass++;
        obs_rd = obs_q.size();
    endtask

    task automatic test_backpressure();
        rec_t e, o;
        int   k;
        sel = 1;
        out_ready = 1'b0;
        drive_beat(3'd0, 1'b0, 1'b0, 64'h3C, 64'h0F, k);
        exp_q.push_back(mk(64'h0C, 1'b0, 1'b0, 8'd1, -1));
        op = 3'd1; accum = 1'b0; last = 1'b0; a = 64'h30; b = 64'h03; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({s_ready, s_valid, s_r[7:0], s_c} !== {1'b0, 1'b1, 8'h0C, 8'd1})
                $display("FAIL stall_%0d: ready=%b valid=%b R=%h count=%0d, required ready=0 valid=1 R=0c count=1",
                         i, s_ready, s_valid, s_r[7:0], s_c);
            else n_pass++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_beat(3'd1, 1'b0, 1'b0, 64'h30, 64'h03, k);
        exp_q.push_back(mk(64'h33, 1'b0, 1'b0, 8'd1, k + 1));
        drive_beat(3'd2, 1'b0, 1'b0, 64'h0F, 64'hFF, k);
        exp_q.push_back(mk(64'hF0, 1'b0, 1'b0, 8'd1, k + 1));
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) $display("FAIL backpressure: no output, required R=%h", e.r);
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.r !== e.r || o.z !== e.z || o.o !== e.o || o.c !== e.c || (e.cyc >= 0 && o.cyc != e.cyc))
                    $display("FAIL backpressure: got R=%h z=%b o=%b cnt=%0d cyc=%0d, required R=%h z=%b o=%b cnt=%0d cyc=%0d",
                             o.r, o.z, o.o, o.c, o.cyc, e.r, e.z, e.o, e.c, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) $display("FAIL backpressure_extra: %0d extra outputs, required 0", obs_q.size() - obs_rd);
        else n_pass++;
        obs_rd = obs_q.size();
    endtask

    task automatic test_interleave();
        rec_t e, o;
        int   k;
        sel = 1;
        drive_beat(3'd1, 1'b1, 1'b0, 64'h01, 64'h00, k);
        drive_beat(3'd0, 1'b0, 1'b0, 64'h3C, 64'h0F, k);
        exp_q.push_back(mk(64'h0C, 1'b0, 1'b0, 8'd1, k + 1));
        drive_beat(3'd0, 1'b1, 1'b1, 64'h80, 64'h00, k);
        exp_q.push_back(mk(64'h81, 1'b0, 1'b0, 8'd2, k + 1));
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) $display("FAIL interleave: no output, required R=%h", e.r);
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.r !== e.r || o.z !== e.z || o.o !== e.o || o.c !== e.c || (e.cyc >= 0 && o.cyc != e.cyc))
                    $display("FAIL interleave: got R=%h z=%b o=%b cnt=%0d cyc=%0d, required R=%h z=%b o=%b cnt=%0d cyc=%0d",
                             o.r, o.z, o.o, o.c, o.cyc, e.r, e.z, e.o, e.c, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) $display("FAIL interleave_extra: %0d extra outputs, required 0", obs_q.size() - obs_rd);
        else n_pass++;
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset_midpacket();
        rec_t e, o;
        int   k;
        sel = 1;
        drive_beat(3'd1, 1'b1, 1'b0, 64'h0F, 64'h00, k);
        drive_beat(3'd1, 1'b1, 1'b0, 64'hF0, 64'h00, k);
        out_ready = 1'b0;
        drive_beat(3'd5, 1'b0, 1'b0, 64'h00, 64'h00, k);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_valid, s_r, s_z, s_o, s_c} !== {1'b0, 64'd0, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset_mid: valid=%b R=%h zero=%b ones=%b count=%0d, required all 0",
                     s_valid, s_r, s_z, s_o, s_c);
        else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_beat(3'd1, 1'b1, 1'b1, 64'h55, 64'h00, k);
        exp_q.push_back(mk(64'h55, 1'b0, 1'b0, 8'd1, k + 1));
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) $display("FAIL reset_packet: no output, required R=%h", e.r);
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.r !== e.r || o.z !== e.z || o.o !== e.o || o.c !== e.c || (e.cyc >= 0 && o.cyc != e.cyc))
                    $display("FAIL reset_packet: got R=%h z=%b o=%b cnt=%0d cyc=%0d, required R=%h z=%b o=%b cnt=%0d cyc=%0d",
                             o.r, o.z, o.o, o.c, o.cyc, e.r, e.z, e.o, e.c, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) $display("FAIL reset_packet_extra: %0d extra outputs, required 0", obs_q.size() - obs_rd);
        else n_pass++;
        obs_rd = obs_q.size();
    endtask

    task automatic test_saturation();
        rec_t e, o;
        int   k;
        sel = 2;
        for (int i = 0; i < 5; i++)
            drive_beat(3'd2, 1'b1, (i == 4), 64'(1 << i), 64'h00, k);
        exp_q.push_back(mk(64'h1F, 1'b0, 1'b0, 8'd3, k + 1));
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) $display("FAIL saturation: no output, required R=%h", e.r);
            else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.r !== e.r || o.z !== e.z || o.o !== e.o || o.c !== e.c || (e.cyc >= 0 && o.cyc != e.cyc))
                    $display("FAIL saturation: got R=%h z=%b o=%b cnt=%0d cyc=%0d, required R=%h z=%b o=%b cnt=%0d cyc=%0d",
                             o.r, o.z, o.o, o.c, o.cyc, e.r, e.z, e.o, e.c, e.cyc);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) $display("FAIL saturation_extra: %0d extra outputs, required 0", obs_q.size() - obs_rd);
        else n_pass++;
        obs_rd = obs_q.size();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        obs_rd   = 0;
        cyc      = 0;
        test_reset();
        test_elementwise();
        test_accumulate();
        test_backpressure();
        test_interleave();
        test_reset_midpacket();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
